// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). At most one request is outstanding.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC, one-outstanding imem handshake, 1-entry skid
// buffer and wrong-path kill. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                StallF,
   input  logic                StallD,
   input  logic                FlushD,
   input  logic                PCSrcD,
   input  logic [31:0]         PCBranchD,
   fetch_stage_if.master       imem,
   output logic [31:0]         InstrD,
   output logic [31:0]         PCPlus4D,
   output logic                ValidD,
   output logic                FetchBusyF
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_fetch_cnt,
   output logic [31:0]         perf_bubble_cnt,
   output logic [15:0]         perf_kill_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        buf_v_q, buf_v_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic        rsp_live;
   logic        req;
   logic        grant;
   logic        busy;

   always_comb begin
      redirect = PCSrcD & ~StallD;
      rsp_live = (state_q == S_WAIT) & imem.imem_rvalid;
      // Back-to-back issue only when the live response can move straight into IF/ID.
      req      = rst_n & ~StallF & ~redirect & ~buf_v_q &
                 ((state_q == S_IDLE) | (rsp_live & ~StallD));
      grant    = req & imem.imem_gnt;

      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_v_d     = buf_v_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      busy        = 1'b0;

      if (redirect) begin
         pc_d    = PCBranchD;
         buf_v_d = 1'b0;
         if (state_q == S_WAIT && !imem.imem_rvalid)
            state_d = S_DRAIN;
         else if (state_q != S_IDLE && imem.imem_rvalid)
            state_d = S_IDLE;
      end else begin
         if (grant) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
            state_d  = S_WAIT;
         end else if (state_q != S_IDLE && imem.imem_rvalid) begin
            state_d = S_IDLE;
         end
         if (rsp_live && StallD) begin
            buf_v_d     = 1'b1;
            buf_instr_d = imem.imem_rdata;
            buf_pc4_d   = req_pc_q + 32'd4;
         end
      end

      // IF/ID load priority: kill, skid buffer, live response, bubble.
      if (!StallD) begin
         if (FlushD || redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else if (buf_v_q) begin
            instr_d = buf_instr_q;
            pc4_d   = buf_pc4_q;
            valid_d = 1'b1;
            buf_v_d = 1'b0;
         end else if (rsp_live) begin
            instr_d = imem.imem_rdata;
            pc4_d   = req_pc_q + 32'd4;
            valid_d = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            busy    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         buf_v_q     <= 1'b0;
         buf_instr_q <= NOP_INSTR;
         buf_pc4_q   <= 32'h0;
         instr_q     <= NOP_INSTR;
         pc4_q       <= 32'h0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_v_q     <= buf_v_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
      end
   end

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;
   assign InstrD         = instr_q;
   assign PCPlus4D       = pc4_q;
   assign ValidD         = valid_q;
   assign FetchBusyF     = busy;

`ifdef FETCH_PERF_CNT_EN
   logic        kill_evt;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [15:0] kill_cnt_q, kill_cnt_d;

   always_comb begin
      // A response is lost when draining, or when a live one meets a kill of IF/ID.
      kill_evt     = ((state_q == S_DRAIN) & imem.imem_rvalid) |
                     (rsp_live & (redirect | (FlushD & ~StallD)));
      fetch_cnt_d  = fetch_cnt_q  + {31'd0, grant};
      bubble_cnt_d = bubble_cnt_q + {31'd0, busy};
      kill_cnt_d   = kill_cnt_q   + {15'd0, kill_evt};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
         kill_cnt_q   <= 16'h0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         kill_cnt_q   <= kill_cnt_d;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
   assign perf_kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register. Feeds InstrD/PCPlus4D to the decode stage and consumes its PCSrcD/PCBranchD redirect.
- Owns PCF, the request/response handshake to instruction memory, a 1-entry skid buffer, and wrong-path kill after redirects.
- Inserts NOP bubbles (32'h00000013) when no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, encoding loaded into InstrD for bubbles and flushes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- StallF  in  1  hazard unit: do not issue new fetch.
- StallD  in  1  hazard unit: hold IF/ID register.
- FlushD  in  1  hazard unit: load bubble into IF/ID.
- PCSrcD  in  1  decode: take redirect.
- PCBranchD  in  32  decode: redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= PCF).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  response instruction.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- FetchBusyF  out  1  no instruction delivered to IF/ID this cycle (hazard/debug).

Behaviour:
- Reset (rst_n=0 at edge):
  - PCF=RESET_PC, FSM=IDLE, buf_v=0.
  - InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - imem_req=0 during the reset cycle.
  - Reset mid-transaction drops everything. Any imem_rvalid arriving later while FSM=IDLE is ignored.
- FSM (response tracking, max one outstanding request):
  - IDLE: no request outstanding.
  - WAIT: request outstanding, live.
  - DRAIN: request outstanding, killed (wrong path).
- redirect = PCSrcD & !StallD.
- imem_req = rst_n & !StallF & !redirect & !buf_v & (FSM==IDLE | (FSM==WAIT & imem_rvalid & !StallD)). imem_addr=PCF.
- Grant (imem_req & imem_gnt): PCF<=PCF+4 (32-bit wrap at 2^32). Next FSM=WAIT. Address/PC of the request are captured as req_pc.
- Response in WAIT:
  - If !StallD: instr goes into IF/ID, ValidD=1, PCPlus4D=req_pc+4.
  - If StallD: instr and req_pc go into the skid buffer (buf_v<=1).
  - FSM->IDLE unless granted the same cycle.
- Response in DRAIN: data dropped, FSM->IDLE.
- Redirect:
  - PCF<=PCBranchD, buf_v<=0, IF/ID<=bubble.
  - WAIT without rvalid -> DRAIN.
  - WAIT with rvalid -> data dropped, IDLE.
  - No request is issued in the redirect cycle.
- IF/ID update when !StallD, priority:
  1. FlushD or redirect -> bubble.
  2. buf_v -> buffer contents, buf_v<=0.
  3. live response -> response.
  4. else bubble.
- Bubble: InstrD=NOP_INSTR, ValidD=0, PCPlus4D unchanged.
- StallD=1: IF/ID holds, even if FlushD=1 (stall dominates flush).
- StallF=1 blocks issue only. An outstanding response is still accepted or buffered.
- Buffer full: no issue until drained. At most one buffered plus one in IF/ID.
- FetchBusyF = !StallD & IF/ID loaded with bubble by rule 4.
- Latency: grant at cycle N, rvalid at N+1 -> InstrD valid at N+2 edge. Back-to-back issue gives 1 instr/cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (grants), perf_bubble_cnt[31:0] (rule-4 bubbles) and perf_kill_cnt[15:0] (dropped responses).
  - Counters clear on reset, increment by 1 per event, and wrap.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, memory with gnt=1 and latency 1 returning addr|0xA000 -> InstrD sequence 0xA000, 0xA004, 0xA008 on consecutive cycles, PCPlus4D=4, 8, 12, ValidD=1.
- StallD=1 for 3 cycles while a response arrives -> InstrD held; response buffered, no new imem_req. Stall release -> buffered instr appears, then fetch resumes at the next PC.
- PCSrcD=1, PCBranchD=0x40 while a request is outstanding (rvalid delayed 2 cycles) -> FSM DRAIN, late data never reaches InstrD. Next imem_addr=0x40.
- Redirect in the same cycle as rvalid -> response dropped, bubble in IF/ID, next request at PCBranchD.
- FlushD=1, StallD=0 -> InstrD=0x00000013, ValidD=0. FlushD=1 with StallD=1 -> IF/ID unchanged.
- rst_n=0 asserted with a request outstanding, then rvalid -> ignored. imem_addr=RESET_PC; perf counters zero when FETCH_PERF_CNT_EN is defined.
